// File: rtl/issue_queue.sv
// Out-of-order issue queue: dispatch into free slots, operand wakeup from broadcast
// channels with dispatch bypass, and oldest-ready selection via an age matrix.
module issue_queue #(
    parameter int DEPTH = 8,
    parameter int NBUS  = 2,
    parameter int DAT_W = 32,
    parameter int TAG_W = 4,
    parameter int OP_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         in_op,
    input  logic                    in_ic,
    input  logic [TAG_W-1:0]        in_qd,
    input  logic [TAG_W-1:0]        in_qj,
    input  logic [TAG_W-1:0]        in_qk,
    input  logic [DAT_W-1:0]        in_vj,
    input  logic [DAT_W-1:0]        in_vk,
    input  logic [DAT_W-1:0]        in_imm,
    input  logic [DAT_W-1:0]        in_pc,
    input  logic [NBUS-1:0]         wb_valid,
    input  logic [NBUS*TAG_W-1:0]   wb_tag,
    input  logic [NBUS*DAT_W-1:0]   wb_data,
    output logic                    iss_valid,
    input  logic                    iss_ready,
    output logic [OP_W-1:0]         iss_op,
    output logic                    iss_ic,
    output logic [TAG_W-1:0]        iss_qd,
    output logic [DAT_W-1:0]        iss_vj,
    output logic [DAT_W-1:0]        iss_vk,
    output logic [DAT_W-1:0]        iss_imm,
    output logic [DAT_W-1:0]        iss_pc,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] busy;
    logic [OP_W-1:0]  op_q  [DEPTH];
    logic             ic_q  [DEPTH];
    logic [TAG_W-1:0] qd_q  [DEPTH];
    logic [TAG_W-1:0] qj_q  [DEPTH];
    logic [TAG_W-1:0] qk_q  [DEPTH];
    logic [DAT_W-1:0] vj_q  [DEPTH];
    logic [DAT_W-1:0] vk_q  [DEPTH];
    logic [DAT_W-1:0] imm_q [DEPTH];
    logic [DAT_W-1:0] pc_q  [DEPTH];
    // older[j][k] = 1 means entry j was dispatched before entry k
    logic [DEPTH-1:0] older [DEPTH];
    logic [CW-1:0]    count_q;

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] sel_oh;
    logic [DEPTH-1:0] disp_oh;
    logic             disp_fire;
    logic             iss_fire;

    logic [DEPTH-1:0] wake_j;
    logic [DEPTH-1:0] wake_k;
    logic [DAT_W-1:0] wake_vj [DEPTH];
    logic [DAT_W-1:0] wake_vk [DEPTH];
    logic             byp_j;
    logic             byp_k;
    logic [DAT_W-1:0] byp_vj;
    logic [DAT_W-1:0] byp_vk;

    // Returns {hit, data} for a tag against all live broadcast channels; tag 0 never hits
    function automatic logic [DAT_W:0] wb_lookup(
        input logic [TAG_W-1:0]      tag,
        input logic [NBUS-1:0]       valid,
        input logic [NBUS*TAG_W-1:0] tags,
        input logic [NBUS*DAT_W-1:0] data
    );
        logic [DAT_W:0] r;
        r = '0;
        for (int n = 0; n < NBUS; n++) begin
            if (valid[n] && (tag != '0) && (tags[n*TAG_W +: TAG_W] == tag)) begin
                r = {1'b1, data[n*DAT_W +: DAT_W]};
            end
        end
        return r;
    endfunction

    assign count     = count_q;
    assign in_ready  = (count_q < CW'(DEPTH));
    assign disp_fire = in_valid && in_ready;
    assign iss_valid = |ready;
    assign iss_fire  = iss_valid && iss_ready;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = busy[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
        end
    end

    // An entry is selected when no other ready entry is older than it
    always_comb begin
        logic blocked;
        sel_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && ready[j] && older[j][i]) begin
                    blocked = 1'b1;
                end
            end
            sel_oh[i] = ready[i] && !blocked;
        end
    end

    always_comb begin
        logic found;
        disp_oh = '0;
        found   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy[i] && !found) begin
                disp_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        logic [DAT_W:0] r;
        for (int i = 0; i < DEPTH; i++) begin
            r          = wb_lookup(qj_q[i], wb_valid, wb_tag, wb_data);
            wake_j[i]  = r[DAT_W];
            wake_vj[i] = r[DAT_W-1:0];
            r          = wb_lookup(qk_q[i], wb_valid, wb_tag, wb_data);
            wake_k[i]  = r[DAT_W];
            wake_vk[i] = r[DAT_W-1:0];
        end
        r      = wb_lookup(in_qj, wb_valid, wb_tag, wb_data);
        byp_j  = r[DAT_W];
        byp_vj = r[DAT_W-1:0];
        r      = wb_lookup(in_qk, wb_valid, wb_tag, wb_data);
        byp_k  = r[DAT_W];
        byp_vk = r[DAT_W-1:0];
    end

    // One-hot select makes the OR-mux naturally zero when nothing is ready
    always_comb begin
        iss_op  = '0;
        iss_ic  = 1'b0;
        iss_qd  = '0;
        iss_vj  = '0;
        iss_vk  = '0;
        iss_imm = '0;
        iss_pc  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                iss_op  = iss_op  | op_q[i];
                iss_ic  = iss_ic  | ic_q[i];
                iss_qd  = iss_qd  | qd_q[i];
                iss_vj  = iss_vj  | vj_q[i];
                iss_vk  = iss_vk  | vk_q[i];
                iss_imm = iss_imm | imm_q[i];
                iss_pc  = iss_pc  | pc_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older[i] <= '0;
                op_q[i]  <= '0;
                ic_q[i]  <= 1'b0;
                qd_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else if (flush) begin
            busy    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && wake_j[i]) begin
                    qj_q[i] <= '0;
                    vj_q[i] <= wake_vj[i];
                end
                if (busy[i] && wake_k[i]) begin
                    qk_q[i] <= '0;
                    vk_q[i] <= wake_vk[i];
                end
                if (iss_fire && sel_oh[i]) begin
                    busy[i] <= 1'b0;
                end
                // The dispatch slot is never busy, so it cannot collide with wakeup or issue
                if (disp_fire && disp_oh[i]) begin
                    busy[i]  <= 1'b1;
                    op_q[i]  <= in_op;
                    ic_q[i]  <= in_ic;
                    qd_q[i]  <= in_qd;
                    qj_q[i]  <= byp_j ? '0 : in_qj;
                    vj_q[i]  <= byp_j ? byp_vj : in_vj;
                    qk_q[i]  <= byp_k ? '0 : in_qk;
                    vk_q[i]  <= byp_k ? byp_vk : in_vk;
                    imm_q[i] <= in_imm;
                    pc_q[i]  <= in_pc;
                    older[i] <= '0;
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j != i) begin
                            older[j][i] <= busy[j];
                        end
                    end
                end
            end
            count_q <= count_q + CW'(disp_fire) - CW'(iss_fire);
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: expected issues are queued at stimulus time
// and checked by a monitor whenever an issue handshake completes.
module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int NBUS  = 2;
    localparam int DAT_W = 32;
    localparam int TAG_W = 4;
    localparam int OP_W  = 6;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [OP_W-1:0]        in_op;
    logic                   in_ic;
    logic [TAG_W-1:0]       in_qd;
    logic [TAG_W-1:0]       in_qj;
    logic [TAG_W-1:0]       in_qk;
    logic [DAT_W-1:0]       in_vj;
    logic [DAT_W-1:0]       in_vk;
    logic [DAT_W-1:0]       in_imm;
    logic [DAT_W-1:0]       in_pc;
    logic [NBUS-1:0]        wb_valid;
    logic [NBUS*TAG_W-1:0]  wb_tag;
    logic [NBUS*DAT_W-1:0]  wb_data;
    logic                   iss_valid;
    logic                   iss_ready;
    logic [OP_W-1:0]        iss_op;
    logic                   iss_ic;
    logic [TAG_W-1:0]       iss_qd;
    logic [DAT_W-1:0]       iss_vj;
    logic [DAT_W-1:0]       iss_vk;
    logic [DAT_W-1:0]       iss_imm;
    logic [DAT_W-1:0]       iss_pc;
    logic [$clog2(DEPTH):0] count;

    typedef struct {
        logic [DAT_W-1:0] pc;
        logic [DAT_W-1:0] vj;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    issue_queue #(
        .DEPTH(DEPTH), .NBUS(NBUS), .DAT_W(DAT_W), .TAG_W(TAG_W), .OP_W(OP_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_ic(in_ic), .in_qd(in_qd), .in_qj(in_qj), .in_qk(in_qk),
        .in_vj(in_vj), .in_vk(in_vk), .in_imm(in_imm), .in_pc(in_pc),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_op(iss_op), .iss_ic(iss_ic), .iss_qd(iss_qd),
        .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_imm(iss_imm), .iss_pc(iss_pc),
        .count(count)
    );

    // Monitor: every completed issue handshake must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && iss_valid && iss_ready) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_issue: got pc=%h, no issue expected", iss_pc);
            end else begin
                e = sb.pop_front();
                if (iss_pc !== e.pc || iss_vj !== e.vj) begin
                    bad++;
                    $display("[TB] FAIL issue_order: got pc=%h vj=%h, want pc=%h vj=%h",
                             iss_pc, iss_vj, e.pc, e.vj);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DAT_W-1:0] got,
                               input logic [DAT_W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // One-cycle dispatch of an entry; wb_* are left as the caller set them
    task automatic applyStimulus(input logic [DAT_W-1:0] pc, input logic [TAG_W-1:0] qj,
                                 input logic [DAT_W-1:0] vj);
        in_valid = 1'b1;
        in_pc    = pc;
        in_op    = pc[OP_W-1:0];
        in_qj    = qj;
        in_qk    = '0;
        in_vj    = vj;
        in_vk    = 32'h0;
        step();
        in_valid = 1'b0;
    endtask

    task automatic clearWb();
        wb_valid = '0;
        wb_tag   = '0;
        wb_data  = '0;
    endtask

    exp_t e;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; iss_ready = 1'b0;
        in_op = '0; in_ic = 1'b0; in_qd = '0; in_qj = '0; in_qk = '0;
        in_vj = '0; in_vk = '0; in_imm = '0; in_pc = '0;
        clearWb();
        step();
        step();
        rst = 1'b0;
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_iss_valid", 32'(iss_valid), 32'd0);
        checkOutput("reset_iss_pc", iss_pc, 32'h0);

        // Three ready entries issue in dispatch order
        e = '{pc: 32'h10, vj: 32'h1}; sb.push_back(e);
        e = '{pc: 32'h20, vj: 32'h2}; sb.push_back(e);
        e = '{pc: 32'h30, vj: 32'h3}; sb.push_back(e);
        iss_ready = 1'b1;
        applyStimulus(32'h10, 4'd0, 32'h1);
        applyStimulus(32'h20, 4'd0, 32'h2);
        applyStimulus(32'h30, 4'd0, 32'h3);
        step();
        step();
        iss_ready = 1'b0;
        checkOutput("inorder_count", 32'(count), 32'd0);
        checkOutput("inorder_drained", 32'(sb.size()), 32'd0);

        // Older A waits on tag 5, younger ready B goes first
        applyStimulus(32'hA0, 4'd5, 32'h0);
        applyStimulus(32'hB0, 4'd0, 32'hB);
        e = '{pc: 32'hB0, vj: 32'hB};  sb.push_back(e);
        e = '{pc: 32'hA0, vj: 32'hAA}; sb.push_back(e);
        iss_ready = 1'b1;
        wb_valid  = 2'b10;
        wb_tag    = {4'd5, 4'd0};
        wb_data   = {32'hAA, 32'h0};
        checkOutput("wake_first_pc", iss_pc, 32'hB0);
        step();
        clearWb();
        checkOutput("wake_next_pc", iss_pc, 32'hA0);
        checkOutput("wake_next_vj", iss_vj, 32'hAA);
        step();
        iss_ready = 1'b0;
        checkOutput("wake_count", 32'(count), 32'd0);

        // Dispatch bypass from channel 0
        wb_valid = 2'b01;
        wb_tag   = {4'd0, 4'd3};
        wb_data  = {32'h0, 32'h55};
        applyStimulus(32'hC0, 4'd3, 32'h0);
        clearWb();
        checkOutput("bypass_valid", 32'(iss_valid), 32'd1);
        checkOutput("bypass_vj", iss_vj, 32'h55);
        e = '{pc: 32'hC0, vj: 32'h55}; sb.push_back(e);
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;

        // Tag-0 broadcast must not disturb any value field
        applyStimulus(32'hD0, 4'd7, 32'h1111);
        applyStimulus(32'hE0, 4'd0, 32'h2222);
        wb_valid = 2'b11;
        wb_tag   = '0;
        wb_data  = {32'hBEEF, 32'hDEAD};
        step();
        clearWb();
        checkOutput("tag0_pc", iss_pc, 32'hE0);
        checkOutput("tag0_vj", iss_vj, 32'h2222);
        wb_valid = 2'b01;
        wb_tag   = {4'd0, 4'd7};
        wb_data  = {32'h0, 32'h77};
        step();
        clearWb();
        e = '{pc: 32'hD0, vj: 32'h77};   sb.push_back(e);
        e = '{pc: 32'hE0, vj: 32'h2222}; sb.push_back(e);
        iss_ready = 1'b1;
        step();
        step();
        iss_ready = 1'b0;
        checkOutput("tag0_count", 32'(count), 32'd0);

        // Fill the queue, drop a 9th dispatch, then free one slot
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(32'h100 + 32'(i), 4'd0, 32'(i));
        end
        checkOutput("full_count", 32'(count), 32'd8);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(32'h1FF, 4'd0, 32'hFF);
        checkOutput("full_drop_count", 32'(count), 32'd8);
        e = '{pc: 32'h100, vj: 32'h0}; sb.push_back(e);
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;
        checkOutput("free_in_ready", 32'(in_ready), 32'd1);
        checkOutput("free_count", 32'(count), 32'd7);

        // Drain to four entries, then flush with a colliding dispatch
        for (int i = 1; i < 4; i++) begin
            e = '{pc: 32'h100 + 32'(i), vj: 32'(i)}; sb.push_back(e);
        end
        iss_ready = 1'b1;
        step();
        step();
        step();
        iss_ready = 1'b0;
        checkOutput("preflush_count", 32'(count), 32'd4);
        flush = 1'b1;
        applyStimulus(32'h2FF, 4'd0, 32'hEE);
        flush = 1'b0;
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_iss_valid", 32'(iss_valid), 32'd0);
        step();
        checkOutput("flush_no_capture", 32'(count), 32'd0);

        // Queue still works after flush
        e = '{pc: 32'h300, vj: 32'h33}; sb.push_back(e);
        iss_ready = 1'b1;
        applyStimulus(32'h300, 4'd0, 32'h33);
        step();
        step();
        iss_ready = 1'b0;
        checkOutput("final_drained", 32'(sb.size()), 32'd0);
        checkOutput("final_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
